multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control unit that sequences the shared 32-bit ALU, register file, PC and unified memory through fetch/decode/execute/memory/writeback.
- Decodes the instruction opcode and drives the ALU operation code and all datapath mux selects and write strobes.
- Stalls on a memory ready handshake.
- Sits between the instruction register and the datapath; it is the only block that drives `alu_op`.

## Interface
Parameters:
- `WORD_SIZE`, 32, datapath width; used only by the perf counters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  4  instruction bits [31:28], taken from the IR output.
- `alu_zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `alu_op`  out  4  ALU opcode: MOV 0, NOT 1, ADD 2, SUB 3, OR 4, AND 5, XOR 6, SLT 7.
- `alu_src_a`  out  1  0 = PC, 1 = A register.
- `alu_src_b`  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`, `iord`, `mem_to_reg`  out  1 each  datapath strobes and selects.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `halted`  out  1  high in HALT.
- `state`  out  3  current state, for debug.
- `retired_cnt`, `cycle_cnt`  out  `WORD_SIZE` each  performance counters.

## Operation
Opcodes:
- 0000–0111: R-type ALU ops.
- 1000: LW.
- 1001: SW.
- 1010: BEQ.
- 1100: JMP.
- 1111: HALT.
- 1011, 1101, 1110: illegal.

Defaults: every strobe is 0 and every select is 0 unless a state listed below drives it.

States and encodings:
- **S_RST (0)**
  - All outputs 0.
  - Next state: FETCH.
- **FETCH (1)**
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD.
  - When `mem_ready`=1 in the same cycle: `ir_write`=1, `pc_write`=1 with `pc_src`=0, next state DECODE.
  - Otherwise: hold in FETCH.
- **DECODE (2)**
  - Drives `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD, precomputing the branch target into ALUOut.
  - HALT → HALT.
  - JMP → `pc_write`=1 with `pc_src`=2, then FETCH.
  - Illegal opcode → `illegal`=1, then FETCH (treated as NOP).
  - All other opcodes → EXEC.
- **EXEC (3)**
  - R-type: `alu_op`=opcode, `alu_src_a`=1, `alu_src_b`=0, then WB.
  - LW/SW: `alu_op`=ADD, `alu_src_a`=1, `alu_src_b`=2, then MEM.
  - BEQ: `alu_op`=SUB, `alu_src_a`=1, `alu_src_b`=0. If `alu_zero`=1, also `pc_write`=1 with `pc_src`=1. Next state FETCH.
- **MEM (4)**
  - Drives `iord`=1.
  - LW: `mem_read`=1. Hold until `mem_ready`, then WB.
  - SW: `mem_write`=1. Hold until `mem_ready`, then FETCH.
- **WB (5)**
  - Drives `reg_write`=1 and `mem_to_reg`=(opcode==LW).
  - Next state FETCH.
- **HALT (6)**
  - `halted`=1, all strobes 0.
  - Stays in HALT until `rst`.

Opcode source: the controller reads `opcode` only in DECODE through MEM/WB. The IR is stable in those states because `ir_write` fires only in FETCH.

## Timing
- Outputs are a combinational decode of the registered state, plus `opcode`, `mem_ready` and `alu_zero`. No output is registered except the counters.
- `rst` sampled high at an edge puts the state in S_RST at that edge, from any state, including mid-memory-wait. The state stays in S_RST while `rst` is high.
- Reset values:
  - All strobes 0, all selects 0, `alu_op`=0.
  - `state`=0, `halted`=0, counters 0.
- Cycle counts with `mem_ready` tied high:
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - JMP: 2 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle `mem_ready`=0 in FETCH or MEM adds exactly one cycle. Strobes qualified by `mem_ready` assert only in the ready cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- The first FETCH occurs one cycle after `rst` deasserts.

## Configuration
Macro: `CTRL_PERF_CNT_EN`.

When defined:
- `cycle_cnt` increments every cycle the state is not S_RST or HALT.
- `retired_cnt` increments on WB exit, SW completion, BEQ EXEC and JMP DECODE.
- Both counters wrap modulo 2^`WORD_SIZE`.
- Both counters clear on `rst`.

When undefined:
- Both ports are tied to 0 and no counter flops are present.
- All other behaviour is identical.

## Test plan
- **Reset entry:** assert `rst` for 3 cycles, then release.
  - `state` = 0 and all strobes 0 during reset.
  - `state` = 1 with `mem_read`=1 one cycle after release.
- **R-type ADD:** opcode 0010, `mem_ready`=1.
  - State sequence 1→2→3→5→1.
  - `alu_op`=2 in EXEC.
  - `reg_write`=1 only in WB.
  - `retired_cnt` increments by 1.
- **LW with memory stalls:** 2 stall cycles in FETCH and 3 stall cycles in MEM.
  - Total 10 cycles.
  - `ir_write` pulses once.
  - `mem_to_reg`=1 in WB.
- **BEQ:** run once with `alu_zero`=1 and once with `alu_zero`=0.
  - `alu_zero`=1: `pc_write`=1 with `pc_src`=1 in EXEC.
  - `alu_zero`=0: no `pc_write` in EXEC.
  - Both cases take 3 cycles.
- **Opcode 1101 then HALT (1111):**
  - 1101 gives a 1-cycle `illegal` pulse and a return to FETCH.
  - HALT then holds `halted`=1 for 20 cycles and `cycle_cnt` freezes.
- **Reset mid-operation:** assert `rst` during a MEM stall of a SW.
  - `mem_write` drops at the next edge.
  - `state` = 0 and counters 0 at that edge.
  - No spurious `reg_write`.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller for the shared-ALU datapath.
// Optional perf counters: define CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           opcode,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic [3:0]           alu_op,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [WORD_SIZE-1:0] retired_cnt,
  output logic [WORD_SIZE-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;

  state_t st_q;
  state_t st_d;

  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_jmp;
  logic is_hlt;
  logic is_ill;

  assign is_r   = ~opcode[3];
  assign is_lw  = (opcode == 4'b1000);
  assign is_sw  = (opcode == 4'b1001);
  assign is_beq = (opcode == 4'b1010);
  assign is_jmp = (opcode == 4'b1100);
  assign is_hlt = (opcode == 4'b1111);
  assign is_ill = (opcode == 4'b1011) |
                  (opcode == 4'b1101) |
                  (opcode == 4'b1110);

  assign state = st_q;

  // State register; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) st_q <= S_RST;
    else     st_q <= st_d;
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    st_d       = st_q;
    alu_op     = 4'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    unique case (st_q)
      S_RST: st_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = OP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          st_d     = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = OP_ADD;
        unique case (1'b1)
          is_hlt: st_d = HALT;
          is_jmp: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            st_d     = FETCH;
          end
          is_ill: begin
            illegal = 1'b1;
            st_d    = FETCH;
          end
          default: st_d = EXEC;
        endcase
      end
      EXEC: begin
        alu_src_a = 1'b1;
        unique case (1'b1)
          is_r: begin
            alu_op = opcode;
            st_d   = WB;
          end
          is_lw, is_sw: begin
            alu_op    = OP_ADD;
            alu_src_b = 2'd2;
            st_d      = MEM;
          end
          default: begin
            alu_op = OP_SUB;
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            st_d = FETCH;
          end
        endcase
      end
      MEM: begin
        iord = 1'b1;
        if (is_lw) mem_read  = 1'b1;
        else       mem_write = 1'b1;
        if (mem_ready) st_d = is_lw ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        st_d       = FETCH;
      end
      HALT: halted = 1'b1;
      default: st_d = S_RST;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;
  logic active;

  assign retire = (st_q == WB) |
                  ((st_q == MEM) & is_sw & mem_ready) |
                  ((st_q == EXEC) & is_beq) |
                  ((st_q == DECODE) & is_jmp);
  assign active = (st_q != S_RST) & (st_q != HALT);

  // Free-running perf counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (active) cycle_cnt   <= cycle_cnt + 1'b1;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule
